// File: rtl/mdu_iter_pkg.sv
// mdu_iter_pkg
// Shared definitions for the iterative multiply/divide unit: the 4-bit
// MDUOP_* operation codes used by the pipeline controller and the MDU,
// the FSM state type, the cycle-counter width and op classification helpers.
package mdu_iter_pkg;

   // Operation codes carried on the 4-bit op bus alongside start.
   localparam logic [3:0] MDUOP_NONE  = 4'd0;
   localparam logic [3:0] MDUOP_MULT  = 4'd1;
   localparam logic [3:0] MDUOP_MULTU = 4'd2;
   localparam logic [3:0] MDUOP_DIV   = 4'd3;
   localparam logic [3:0] MDUOP_DIVU  = 4'd4;
   localparam logic [3:0] MDUOP_MTHI  = 4'd5;
   localparam logic [3:0] MDUOP_MTLO  = 4'd6;

   // Busy-cycle counts are limited to 1..31, so 5 bits suffice.
   localparam int CNT_W = 5;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } mdu_state_e;

   function automatic logic is_mul(input logic [3:0] op);
      return (op == MDUOP_MULT) || (op == MDUOP_MULTU);
   endfunction

   function automatic logic is_div(input logic [3:0] op);
      return (op == MDUOP_DIV) || (op == MDUOP_DIVU);
   endfunction

endpackage

// File: rtl/mdu_iter_core.sv
// mdu_core
// Combinational datapath of the MDU. Produces the HI/LO result for the
// latched operation and operands; the multi-cycle timing lives in mdu_iter.
// Ports:
//   op_i    : latched MDUOP_* code
//   a_i     : latched rs operand (dividend / multiplicand)
//   b_i     : latched rt operand (divisor / multiplier)
//   res_hi  : HI result (product high word / remainder)
//   res_lo  : LO result (product low word / quotient)
module mdu_core
   import mdu_iter_pkg::*;
(
   input  logic [3:0]  op_i,
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   output logic [31:0] res_hi,
   output logic [31:0] res_lo
);

   // Operands are widened explicitly so the 64-bit product is exact for
   // both signed and unsigned multiplies.
   logic [63:0] a_sx, b_sx, a_zx, b_zx;
   logic [63:0] prod_s, prod_u;
   logic [31:0] quot_s, rem_s, quot_u, rem_u;
   logic        div_zero, div_ovf;

   assign a_sx   = {{32{a_i[31]}}, a_i};
   assign b_sx   = {{32{b_i[31]}}, b_i};
   assign a_zx   = {32'd0, a_i};
   assign b_zx   = {32'd0, b_i};
   assign prod_s = a_sx * b_sx;
   assign prod_u = a_zx * b_zx;

   // Signed division truncates toward zero and the remainder follows the
   // sign of the dividend. Zero-divisor results are discarded below.
   assign quot_s = $signed(a_i) / $signed(b_i);
   assign rem_s  = $signed(a_i) % $signed(b_i);
   assign quot_u = a_i / b_i;
   assign rem_u  = a_i % b_i;

   assign div_zero = (b_i == 32'd0);
   // The single signed quotient that does not fit in 32 bits.
   assign div_ovf  = (a_i == 32'h8000_0000) && (b_i == 32'hFFFF_FFFF);

   // NOTE: every output gets a default first so no path through the case
   // leaves it unassigned, which would infer a latch.
   always_comb begin
      res_hi = 32'd0;
      res_lo = 32'd0;
      case (op_i)
         MDUOP_MULT:  {res_hi, res_lo} = prod_s;
         MDUOP_MULTU: {res_hi, res_lo} = prod_u;
         MDUOP_DIV: begin
            if (div_zero) begin
               res_lo = 32'hFFFF_FFFF;
               res_hi = a_i;
            end else if (div_ovf) begin
               res_lo = 32'h8000_0000;
               res_hi = 32'd0;
            end else begin
               res_lo = quot_s;
               res_hi = rem_s;
            end
         end
         MDUOP_DIVU: begin
            if (div_zero) begin
               res_lo = 32'hFFFF_FFFF;
               res_hi = a_i;
            end else begin
               res_lo = quot_u;
               res_hi = rem_u;
            end
         end
         default: begin
            res_hi = 32'd0;
            res_lo = 32'd0;
         end
      endcase
   end

endmodule

// File: rtl/mdu_iter.sv
// mdu_iter
// Iterative multiply/divide unit owning the architectural HI/LO registers.
// MULT/MULTU/DIV/DIVU are accepted in IDLE, run for a fixed cycle count with
// busy high, and commit HI/LO on the edge that busy falls. MTHI/MTLO write
// HI/LO directly in IDLE with no busy cycle. Requests during RUN are ignored.
// Ports:
//   clk, reset_n : clock (rising edge), asynchronous active-low reset
//   start, op    : request strobe and MDUOP_* code
//   A, B         : rs / rt operands
//   busy         : operation in flight (registered)
//   hi, lo       : architectural HI / LO registers
module mdu_iter
   import mdu_iter_pkg::*;
#(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic [3:0]  op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   mdu_state_e         state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               busy_q, busy_d;
   logic [3:0]         op_q, op_d;
   logic [31:0]        a_q, a_d;
   logic [31:0]        b_q, b_d;
   logic [31:0]        hi_q, hi_d;
   logic [31:0]        lo_q, lo_d;
   logic [31:0]        res_hi, res_lo;

   // The core only ever sees the latched operands, so input changes during
   // RUN cannot disturb the result.
   mdu_core u_core (
      .op_i   (op_q),
      .a_i    (a_q),
      .b_i    (b_q),
      .res_hi (res_hi),
      .res_lo (res_lo)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (is_mul(op) || is_div(op)) begin
                  op_d    = op;
                  a_d     = A;
                  b_d     = B;
                  cnt_d   = is_mul(op) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                  busy_d  = 1'b1;
                  state_d = ST_RUN;
               end else if (op == MDUOP_MTHI) begin
                  hi_d = A;
               end else if (op == MDUOP_MTLO) begin
                  lo_d = A;
               end
            end
         end
         ST_RUN: begin
            // The counter was loaded with N on accept; the edge that takes it
            // from 1 to 0 is edge t0+N and commits the result.
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
               hi_d    = res_hi;
               lo_d    = res_lo;
               busy_d  = 1'b0;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: state is updated with non-blocking assignments so every flop
   // samples the pre-edge values computed above.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         op_q    <= MDUOP_NONE;
         a_q     <= '0;
         b_q     <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   assign busy = busy_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule
